// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin arbiter that shares one spi_master_ss core
// among NUM_REQ requesters. Each requester has its own arm/data handshake.
// The arbiter grants the core to one requester at a time, forwards that
// requester's word and arm, and routes the core's finished flag back to it.
//
// Optional feature: define SPI_MASTER_ARBITER_TIMEOUT_EN to build a DONE-state
// release timer. When TIMEOUT_CYCLES cycles pass in DONE, the arbiter forces
// the grant away from the requester and pulses `timeout`. Without the macro,
// `timeout` is tied low and DONE waits indefinitely.
module spi_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int REQ_LEN        = 1,
  parameter int WID            = 24,
  parameter int TIMEOUT_LEN    = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   rst_L,
  input  logic [NUM_REQ-1:0]     req_arm,
  input  logic [NUM_REQ*WID-1:0] req_to_slave,
  output logic [NUM_REQ-1:0]     req_finished,
  output logic [NUM_REQ-1:0]     grant,
  output logic [WID-1:0]         from_slave,
  output logic                   spi_arm,
  output logic [WID-1:0]         spi_to_slave,
  input  logic [WID-1:0]         spi_from_slave,
  input  logic                   spi_finished,
  input  logic                   spi_ready_to_arm,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [REQ_LEN-1:0]   last_q, last_d;
  logic [REQ_LEN-1:0]   gidx_q, gidx_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic                 arm_d;
  logic [WID-1:0]       tx_d;

  logic [NUM_REQ-1:0]   eligible;
  logic                 sel_found;
  logic [REQ_LEN-1:0]   sel_idx;
  logic [WID-1:0]       sel_word;

`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
  logic [TIMEOUT_LEN-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     blocked_q, blocked_d;
  logic                   timeout_d;

  // A requester that timed out stays out of arbitration until it drops arm
  assign eligible = req_arm & ~blocked_q;
`else
  assign eligible = req_arm;
  assign timeout  = 1'b0;
`endif

  // Core results pass straight through; only the grantee sees finished
  assign from_slave   = spi_from_slave;
  assign req_finished = grant & {NUM_REQ{spi_finished}};

  // Round-robin pick: first eligible requester searching upward from last+1
  always_comb begin
    int unsigned cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_word  = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = {{(32-REQ_LEN){1'b0}}, last_q} + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!sel_found && eligible[REQ_LEN'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = REQ_LEN'(cand);
        sel_word  = req_to_slave[cand*WID +: WID];
      end
    end
  end

  // Next-state and registered-output logic for the grant FSM
  always_comb begin
    state_d = state_q;
    grant_d = grant;
    arm_d   = spi_arm;
    tx_d    = spi_to_slave;
    last_d  = last_q;
    gidx_d  = gidx_q;
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
    cnt_d     = cnt_q;
    blocked_d = blocked_q & req_arm;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (spi_ready_to_arm && sel_found) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          tx_d             = sel_word;
          arm_d            = 1'b1;
          gidx_d           = sel_idx;
          state_d          = S_BUSY;
        end
      end
      S_BUSY: begin
        if (spi_finished) begin
          state_d = S_DONE;
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (!req_arm[gidx_q]) begin
          arm_d   = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        // arm stays high here so the core keeps finished/from_slave stable
        if (!req_arm[gidx_q]) begin
          arm_d   = 1'b0;
          state_d = S_DRAIN;
        end
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LEN'(TIMEOUT_CYCLES - 1)) begin
          arm_d             = 1'b0;
          state_d           = S_DRAIN;
          timeout_d         = 1'b1;
          blocked_d[gidx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DRAIN: begin
        if (spi_ready_to_arm) begin
          grant_d = '0;
          last_d  = gidx_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves requester 0 at top priority
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q      <= S_IDLE;
      grant        <= '0;
      spi_arm      <= 1'b0;
      spi_to_slave <= '0;
      last_q       <= REQ_LEN'(NUM_REQ - 1);
      gidx_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant        <= grant_d;
      spi_arm      <= arm_d;
      spi_to_slave <= tx_d;
      last_q       <= last_d;
      gidx_q       <= gidx_d;
    end
  end

`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
  // Release-timer, per-requester block mask and timeout pulse
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      cnt_q     <= '0;
      blocked_q <= '0;
      timeout   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      blocked_q <= blocked_d;
      timeout   <= timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed testbench for spi_master_arbiter with a behavioural SPI core model
// and a scoreboard of expected (requester, word) results.
module tb_spi_master_arbiter;

  localparam int NUM_REQ = 2;
  localparam int REQ_LEN = 1;
  localparam int WID     = 24;

  logic                   clk;
  logic                   rst_L;
  logic [NUM_REQ-1:0]     req_arm;
  logic [NUM_REQ*WID-1:0] req_to_slave;
  logic [NUM_REQ-1:0]     req_finished;
  logic [NUM_REQ-1:0]     grant;
  logic [WID-1:0]         from_slave;
  logic                   spi_arm;
  logic [WID-1:0]         spi_to_slave;
  logic [WID-1:0]         spi_from_slave;
  logic                   spi_finished;
  logic                   spi_ready_to_arm;
  logic                   timeout;

  int passed;
  int total;
  int fails;

  typedef struct {
    int unsigned    idx;
    logic [WID-1:0] word;
  } exp_t;

  exp_t sb[$];

`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
  spi_master_arbiter #(
    .NUM_REQ(NUM_REQ), .REQ_LEN(REQ_LEN), .WID(WID),
    .TIMEOUT_LEN(16), .TIMEOUT_CYCLES(8)
  ) dut (
`else
  spi_master_arbiter #(
    .NUM_REQ(NUM_REQ), .REQ_LEN(REQ_LEN), .WID(WID)
  ) dut (
`endif
    .clk(clk), .rst_L(rst_L), .req_arm(req_arm), .req_to_slave(req_to_slave),
    .req_finished(req_finished), .grant(grant), .from_slave(from_slave),
    .spi_arm(spi_arm), .spi_to_slave(spi_to_slave),
    .spi_from_slave(spi_from_slave), .spi_finished(spi_finished),
    .spi_ready_to_arm(spi_ready_to_arm), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural spi_master_ss: takes arm when ready, finishes 4 cycles later,
  // returns the inverted word, holds finished while armed, recovers on disarm.
  logic       c_busy;
  logic [2:0] c_cnt;
  always @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      c_busy           <= 1'b0;
      c_cnt            <= '0;
      spi_ready_to_arm <= 1'b1;
      spi_finished     <= 1'b0;
      spi_from_slave   <= '0;
    end else if (!c_busy) begin
      if (spi_arm && spi_ready_to_arm) begin
        c_busy           <= 1'b1;
        spi_ready_to_arm <= 1'b0;
        c_cnt            <= 3'd3;
        spi_from_slave   <= spi_to_slave ^ {WID{1'b1}};
      end
    end else if (!spi_arm) begin
      c_busy           <= 1'b0;
      spi_finished     <= 1'b0;
      spi_ready_to_arm <= 1'b1;
    end else if (c_cnt != 0) begin
      c_cnt <= c_cnt - 1'b1;
    end else begin
      spi_finished <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a finished pulse, then compare it against the scoreboard
  task automatic wait_finish(input string tag);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(posedge clk); #1;
      if (|req_finished) seen = 1'b1;
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_onehot"}, 64'(req_finished), 64'd1 << e.idx);
      check({tag, "_data"}, 64'(from_slave), 64'(e.word ^ {WID{1'b1}}));
    end
  endtask

  // Drop a requester's arm and wait (bounded) until the grant clears
  task automatic release_req(input int unsigned idx, input string tag);
    bit cleared;
    cleared = 1'b0;
    req_arm[idx] = 1'b0;
    for (int i = 0; i < 64 && !cleared; i++) begin
      @(posedge clk); #1;
      if (grant == '0) cleared = 1'b1;
    end
    check(tag, 64'(grant), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    passed = 0;
    total  = 0;
    fails  = 0;

    // Reset values
    rst_L        = 1'b0;
    req_arm      = '0;
    req_to_slave = {24'hA5A5A5, 24'h000000};
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_arm", 64'(spi_arm), 64'd0);
    check("rst_tx", 64'(spi_to_slave), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);

    // Requester 1 alone: 1-cycle arm-to-grant latency
    rst_L   = 1'b1;
    req_arm = 2'b10;
    sb.push_back('{idx: 1, word: 24'hA5A5A5});
    @(posedge clk); #1;
    check("r1_grant", 64'(grant), 64'd2);
    check("r1_arm", 64'(spi_arm), 64'd1);
    check("r1_tx", 64'(spi_to_slave), 64'hA5A5A5);
    wait_finish("r1");
    release_req(1, "r1_rel");

    // Contention: both held, re-arming, served 0,1,0,1
    req_to_slave = {24'h222222, 24'h111111};
    sb.push_back('{idx: 0, word: 24'h111111});
    sb.push_back('{idx: 1, word: 24'h222222});
    req_arm = 2'b11;
    wait_finish("rr0");
    release_req(0, "rr0_rel");
    sb.push_back('{idx: 0, word: 24'h111111});
    req_arm[0] = 1'b1;
    wait_finish("rr1");
    release_req(1, "rr1_rel");
    sb.push_back('{idx: 1, word: 24'h222222});
    req_arm[1] = 1'b1;
    wait_finish("rr2");
    release_req(0, "rr2_rel");
    wait_finish("rr3");
    release_req(1, "rr3_rel");

    // Data latch: word change mid-transfer is ignored
    req_to_slave = {24'h222222, 24'h123456};
    sb.push_back('{idx: 0, word: 24'h123456});
    req_arm = 2'b01;
    @(posedge clk); #1;
    check("latch_tx0", 64'(spi_to_slave), 64'h123456);
    req_to_slave = {24'h222222, 24'hFFFFFF};
    repeat (2) @(posedge clk);
    #1;
    check("latch_tx1", 64'(spi_to_slave), 64'h123456);
    wait_finish("latch");
    release_req(0, "latch_rel");

    // Abort: requester 1 (next in turn) drops arm in BUSY; pending 0 goes next
    sb.push_back('{idx: 0, word: 24'hFFFFFF});
    req_arm = 2'b11;
    @(posedge clk); #1;
    check("abort_grant", 64'(grant), 64'd2);
    req_arm[1] = 1'b0;
    @(posedge clk); #1;
    check("abort_arm", 64'(spi_arm), 64'd0);
    check("abort_hold", 64'(grant), 64'd2);
    cnt = 0;
    while (grant != '0 && cnt < 64) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("abort_clear", 64'(grant), 64'd0);
    @(posedge clk); #1;
    check("abort_next", 64'(grant), 64'd1);
    wait_finish("abort");
    release_req(0, "abort_rel");

`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
    // Timeout: grantee holds arm after finish
    sb.push_back('{idx: 1, word: 24'h222222});
    req_arm = 2'b10;
    wait_finish("to");
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (timeout || !spi_arm) cnt++;
    end
    check("to_early", 64'(cnt), 64'd0);
    @(posedge clk); #1;
    check("to_pulse", 64'(timeout), 64'd1);
    check("to_arm", 64'(spi_arm), 64'd0);
    @(posedge clk); #1;
    check("to_once", 64'(timeout), 64'd0);
    cnt = 0;
    while (grant != '0 && cnt < 64) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("to_clear", 64'(grant), 64'd0);
    cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (grant != '0) cnt++;
    end
    check("to_blocked", 64'(cnt), 64'd0);
    req_arm[1] = 1'b0;
    @(posedge clk); #1;
    sb.push_back('{idx: 1, word: 24'h222222});
    req_arm[1] = 1'b1;
    @(posedge clk); #1;
    check("to_regrant", 64'(grant), 64'd2);
    wait_finish("to_re");
    release_req(1, "to_rel");
`else
    // Without the timer DONE holds arm indefinitely
    sb.push_back('{idx: 1, word: 24'h222222});
    req_arm = 2'b10;
    wait_finish("hold");
    cnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (spi_arm && !timeout) cnt++;
    end
    check("hold_arm", 64'(cnt), 64'd100);
    release_req(1, "hold_rel");
`endif

    // Asynchronous reset mid-BUSY
    req_arm = 2'b01;
    @(posedge clk); #1;
    check("arst_grant", 64'(grant), 64'd1);
    @(posedge clk); #1;
    #2;
    rst_L = 1'b0;
    #1;
    check("arst_grant0", 64'(grant), 64'd0);
    check("arst_arm0", 64'(spi_arm), 64'd0);
    req_arm = '0;
    @(posedge clk); #1;
    rst_L = 1'b1;
    @(posedge clk); #1;
    check("arst_idle", 64'(grant), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
